// File: rtl/m_pkt_tx.sv
// Net-side packet transmitter: turns a byte-length descriptor plus a stream of
// source data words into a framed vld/sop/eop/length/data word stream.
module m_pkt_tx #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned MAX_LEN    = 1536,
  parameter int unsigned IPG_CYCLES = 2
) (
  input  logic              clk_net,
  input  logic              rst_net,
  input  logic              desc_vld_w,
  input  logic [LEN_W-1:0]  desc_len_w,
  output logic              desc_rdy_w,
  input  logic              dat_vld_w,
  input  logic [DATA_W-1:0] dat_data_w,
  output logic              dat_rdy_w,
  output logic              out_vld_r,
  output logic              out_sop_r,
  output logic              out_eop_r,
  output logic [LEN_W-1:0]  out_length_r,
  output logic [DATA_W-1:0] out_data_r,
  output logic              err_len_r,
  output logic [31:0]       tx_pkt_cnt_r
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned GAP_W = (IPG_CYCLES > 0) ? $clog2(IPG_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    words_rem_q, words_rem_d;
  logic                first_q, first_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                out_vld_q, out_vld_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;
  logic [LEN_W-1:0]    out_length_q, out_length_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                err_len_q, err_len_d;
  logic [31:0]         tx_pkt_cnt_q, tx_pkt_cnt_d;

  logic [31:0]         tail;
  logic [DATA_W-1:0]   masked_data;
  logic                last_beat;
  logic                len_bad;
  logic [LEN_W-1:0]    desc_words;

  assign desc_rdy_w = (state_q == IDLE);
  assign dat_rdy_w  = (state_q == XFER);

  assign len_bad    = (desc_len_w == '0) || (32'(desc_len_w) > MAX_LEN);
  assign desc_words = LEN_W'((32'(desc_len_w) + BYTES - 1) / BYTES);
  assign last_beat  = (words_rem_q == LEN_W'(1));

  // Zero the bytes past the packet end; only applied to the eop word.
  always_comb begin
    masked_data = dat_data_w;
    tail        = 32'(len_q) % BYTES;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if ((tail != 32'd0) && (b >= tail)) masked_data[8*b +: 8] = 8'h00;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    words_rem_d  = words_rem_q;
    first_d      = first_q;
    gap_cnt_d    = gap_cnt_q;
    out_vld_d    = 1'b0;
    out_sop_d    = 1'b0;
    out_eop_d    = 1'b0;
    out_length_d = out_length_q;
    out_data_d   = '0;
    err_len_d    = 1'b0;
    tx_pkt_cnt_d = tx_pkt_cnt_q;

    case (state_q)
      IDLE: begin
        if (desc_vld_w) begin
          if (len_bad) begin
            err_len_d = 1'b1;
          end else begin
            len_d       = desc_len_w;
            words_rem_d = desc_words;
            first_d     = 1'b1;
            state_d     = XFER;
          end
        end
      end
      XFER: begin
        if (dat_vld_w) begin
          out_vld_d    = 1'b1;
          out_sop_d    = first_q;
          out_eop_d    = last_beat;
          out_length_d = len_q;
          out_data_d   = last_beat ? masked_data : dat_data_w;
          words_rem_d  = words_rem_q - LEN_W'(1);
          first_d      = 1'b0;
          if (last_beat) begin
            tx_pkt_cnt_d = tx_pkt_cnt_q + 32'd1;
            if (IPG_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d   = GAP;
              gap_cnt_d = GAP_W'(IPG_CYCLES);
            end
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q <= GAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_net or posedge rst_net) begin
    if (rst_net) begin
      state_q      <= IDLE;
      len_q        <= '0;
      words_rem_q  <= '0;
      first_q      <= 1'b0;
      gap_cnt_q    <= '0;
      out_vld_q    <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_length_q <= '0;
      out_data_q   <= '0;
      err_len_q    <= 1'b0;
      tx_pkt_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      words_rem_q  <= words_rem_d;
      first_q      <= first_d;
      gap_cnt_q    <= gap_cnt_d;
      out_vld_q    <= out_vld_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_length_q <= out_length_d;
      out_data_q   <= out_data_d;
      err_len_q    <= err_len_d;
      tx_pkt_cnt_q <= tx_pkt_cnt_d;
    end
  end

  assign out_vld_r    = out_vld_q;
  assign out_sop_r    = out_sop_q;
  assign out_eop_r    = out_eop_q;
  assign out_length_r = out_length_q;
  assign out_data_r   = out_data_q;
  assign err_len_r    = err_len_q;
  assign tx_pkt_cnt_r = tx_pkt_cnt_q;

endmodule

// File: tb/tb_m_pkt_tx.sv
// Directed, table-driven bench for m_pkt_tx (DATA_W=64, IPG_CYCLES=2).
module tb_m_pkt_tx;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned LEN_W  = 16;

  logic              clk_net = 1'b0;
  logic              rst_net = 1'b1;
  logic              desc_vld_w = 1'b0;
  logic [LEN_W-1:0]  desc_len_w = '0;
  logic              desc_rdy_w;
  logic              dat_vld_w = 1'b0;
  logic [DATA_W-1:0] dat_data_w = '0;
  logic              dat_rdy_w;
  logic              out_vld_r, out_sop_r, out_eop_r, err_len_r;
  logic [LEN_W-1:0]  out_length_r;
  logic [DATA_W-1:0] out_data_r;
  logic [31:0]       tx_pkt_cnt_r;

  m_pkt_tx #(.DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_LEN(1536), .IPG_CYCLES(2)) dut (
    .clk_net(clk_net), .rst_net(rst_net),
    .desc_vld_w(desc_vld_w), .desc_len_w(desc_len_w), .desc_rdy_w(desc_rdy_w),
    .dat_vld_w(dat_vld_w), .dat_data_w(dat_data_w), .dat_rdy_w(dat_rdy_w),
    .out_vld_r(out_vld_r), .out_sop_r(out_sop_r), .out_eop_r(out_eop_r),
    .out_length_r(out_length_r), .out_data_r(out_data_r),
    .err_len_r(err_len_r), .tx_pkt_cnt_r(tx_pkt_cnt_r)
  );

  always #5 clk_net = ~clk_net;

  typedef struct {
    int len;
    int exp_words;
    int exp_tail;
    int bubble;
  } vec_t;

  typedef struct {
    int                cyc;
    logic              sop;
    logic              eop;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } obs_t;

  vec_t vecs[8];
  obs_t obs_q[$];
  int   cyc = 0;
  int   err_seen = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Capture every egress word; idle cycles must carry zero sop/eop/data.
  always @(negedge clk_net) begin
    cyc++;
    if (!rst_net) begin
      if (err_len_r) err_seen++;
      if (out_vld_r) obs_q.push_back('{cyc, out_sop_r, out_eop_r, out_length_r, out_data_r});
      else chk("idle_zero", 128'({out_sop_r, out_eop_r, out_data_r}), 128'(0));
    end
  end

  function automatic logic [DATA_W-1:0] word_val(input int base, input int w);
    logic [DATA_W-1:0] v;
    for (int b = 0; b < 8; b++) v[8*b +: 8] = 8'(base + w*8 + b + 1);
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] exp_word(input int base, input int w, input int nw, input int tail);
    logic [DATA_W-1:0] v;
    v = word_val(base, w);
    if (w == nw - 1 && tail != 0)
      for (int b = 0; b < 8; b++) if (b >= tail) v[8*b +: 8] = 8'h00;
    return v;
  endfunction

  task automatic send_desc(input int len);
    int n;
    n = 0;
    @(negedge clk_net);
    desc_vld_w = 1'b1;
    desc_len_w = 16'(len);
    while (!desc_rdy_w && n < 50) begin
      @(negedge clk_net);
      n++;
    end
    if (n >= 50) chk("desc_timeout", 128'(n), 128'(0));
    @(negedge clk_net);
    desc_vld_w = 1'b0;
  endtask

  task automatic send_beats(input int nwords, input int bubble, input int base);
    int n;
    for (int w = 0; w < nwords; w++) begin
      if (w == 1 && bubble > 0) begin
        dat_vld_w = 1'b0;
        repeat (bubble) @(negedge clk_net);
      end
      dat_vld_w  = 1'b1;
      dat_data_w = word_val(base, w);
      n = 0;
      while (!dat_rdy_w && n < 50) begin
        @(negedge clk_net);
        n++;
      end
      if (n >= 50) chk("beat_timeout", 128'(n), 128'(0));
      @(negedge clk_net);
    end
    dat_vld_w = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int nw, base;
    nw   = vecs[i].exp_words;
    base = i * 37;
    obs_q.delete();
    err_seen = 0;
    send_desc(vecs[i].len);
    send_beats(nw, vecs[i].bubble, base);
    repeat (3) @(negedge clk_net);
    exp_cnt++;
    chk($sformatf("v%0d_nwords", i), 128'(obs_q.size()), 128'(nw));
    for (int w = 0; w < nw && w < obs_q.size(); w++)
      chk($sformatf("v%0d_w%0d", i, w),
          128'({obs_q[w].sop, obs_q[w].eop, obs_q[w].len, obs_q[w].data}),
          128'({w == 0, w == nw - 1, 16'(vecs[i].len), exp_word(base, w, nw, vecs[i].exp_tail)}));
    if (vecs[i].bubble > 0 && obs_q.size() > 1)
      chk($sformatf("v%0d_bubble", i), 128'(obs_q[1].cyc - obs_q[0].cyc - 1), 128'(vecs[i].bubble));
    chk($sformatf("v%0d_pkt_cnt", i), 128'(tx_pkt_cnt_r), 128'(exp_cnt));
    chk($sformatf("v%0d_no_err", i), 128'(err_seen), 128'(0));
  endtask

  task automatic run_bad(input int len);
    obs_q.delete();
    err_seen = 0;
    send_desc(len);
    repeat (3) @(negedge clk_net);
    chk($sformatf("bad%0d_err_pulse", len), 128'(err_seen), 128'(1));
    chk($sformatf("bad%0d_no_out", len), 128'(obs_q.size()), 128'(0));
  endtask

  initial begin
    vecs[0] = '{20,   3,   4, 0};
    vecs[1] = '{8,    1,   0, 0};
    vecs[2] = '{1,    1,   1, 0};
    vecs[3] = '{64,   8,   0, 0};
    vecs[4] = '{24,   3,   0, 4};
    vecs[5] = '{9,    2,   1, 0};
    vecs[6] = '{1536, 192, 0, 0};
    vecs[7] = '{15,   2,   7, 0};

    #2;
    chk("rst_outputs", 128'({out_vld_r, out_sop_r, out_eop_r, out_length_r, out_data_r, err_len_r}), 128'(0));
    chk("rst_cnt", 128'(tx_pkt_cnt_r), 128'(0));
    chk("rst_rdy", 128'({desc_rdy_w, dat_rdy_w}), 128'(2'b10));
    repeat (2) @(negedge clk_net);
    rst_net = 1'b0;

    run_vec(0);
    run_vec(1);
    run_vec(2);
    run_bad(0);
    run_bad(1537);
    run_bad(65535);
    for (int i = 3; i < 8; i++) run_vec(i);

    // Back-to-back packets: minimum gap between eop and next sop.
    obs_q.delete();
    send_desc(16);
    send_beats(2, 0, 200);
    send_desc(16);
    send_beats(2, 0, 100);
    repeat (3) @(negedge clk_net);
    exp_cnt += 2;
    chk("b2b_nwords", 128'(obs_q.size()), 128'(4));
    if (obs_q.size() == 4) begin
      chk("b2b_eop_sop", 128'({obs_q[1].eop, obs_q[2].sop}), 128'(2'b11));
      chk("b2b_gap", 128'(obs_q[2].cyc - obs_q[1].cyc - 1), 128'(3));
      chk("b2b_data", 128'(obs_q[3].data), 128'(word_val(100, 1)));
    end
    chk("b2b_pkt_cnt", 128'(tx_pkt_cnt_r), 128'(exp_cnt));

    // Reset while the second word of a 32-byte packet is on the output.
    send_desc(32);
    dat_vld_w  = 1'b1;
    dat_data_w = word_val(9, 0);
    @(negedge clk_net);
    dat_data_w = word_val(9, 1);
    @(negedge clk_net);
    chk("mid_word2", 128'({out_vld_r, out_sop_r, out_data_r}), 128'({2'b10, word_val(9, 1)}));
    rst_net   = 1'b1;
    dat_vld_w = 1'b0;
    #1;
    chk("mid_rst_outputs", 128'({out_vld_r, out_sop_r, out_eop_r, out_length_r, out_data_r, err_len_r}), 128'(0));
    chk("mid_rst_cnt", 128'(tx_pkt_cnt_r), 128'(0));
    chk("mid_rst_idle", 128'({desc_rdy_w, dat_rdy_w}), 128'(2'b10));
    @(negedge clk_net);
    rst_net = 1'b0;
    exp_cnt = 0;
    run_vec(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
